// File: rtl/i2c_pkg.sv
// Shared types and helpers for the single-byte I2C controller.
// - state_e   : transaction FSM states
// - quarter_e : quarter index within one SCL bit period
// - I2C_READ / I2C_WRITE / I2C_ACK : bus-level bit values
// - bus_drive : open-drain enables {scl_oe, sda_oe} for a state/quarter
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_ACK   = 1'b0;

    // Returns {scl_oe, sda_oe}. drive_low is the SDA pull-down request for
    // ordinary bit periods; it is held for the whole bit so SDA only moves
    // at Q0 entry while SCL is being pulled low.
    function automatic logic [1:0] bus_drive(input state_e   st,
                                             input quarter_e q,
                                             input logic     drive_low);
        logic [1:0] lines;
        lines = 2'b00;
        case (st)
            IDLE: lines = 2'b00;
            START: begin
                case (q)
                    Q0, Q1:  lines = 2'b00;
                    Q2:      lines = 2'b01;
                    default: lines = 2'b11;
                endcase
            end
            STOP: begin
                case (q)
                    Q0:      lines = 2'b11;
                    Q1, Q2:  lines = 2'b01;
                    default: lines = 2'b00;
                endcase
            end
            default: lines = {(q == Q0) || (q == Q1), drive_low};
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/i2c_controller_xfer_if.sv
// Request/bus bundle of the single-byte I2C controller.
// - start/addr/rw/wdata : transaction request from the host side
// - sda_in              : resolved SDA line level (asynchronous)
// - scl_oe/sda_oe       : open-drain pull-down enables
// - rdata/busy/done/ack_error : transaction status back to the host
// Modport master is the controller's view; slave is the host/bus view.
interface i2c_controller_xfer_if;

    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_error;

    modport master (
        input  start, addr, rw, wdata, sda_in,
        output scl_oe, sda_oe, rdata, busy, done, ack_error
    );

    modport slave (
        output start, addr, rw, wdata, sda_in,
        input  scl_oe, sda_oe, rdata, busy, done, ack_error
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timebase.
// - clk, rst  : system clock, asynchronous active-low reset
// - run       : count while high; counter and quarter held at 0 when low
// - tick      : high on the last clk of each quarter
// - quarter   : current quarter index Q0..Q3
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     run,
    output logic     tick,
    output quarter_e quarter
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    quarter_e      quarter_q, quarter_d;

    assign tick    = run && (cnt_q == CNT_LAST);
    assign quarter = quarter_q;

    always_comb begin
        cnt_d     = '0;
        quarter_d = Q0;
        if (run) begin
            if (tick) begin
                cnt_d     = '0;
                quarter_d = quarter_e'(quarter_q + 2'd1);
            end else begin
                cnt_d     = cnt_q + 1'b1;
                quarter_d = quarter_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            quarter_q <= Q0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

endmodule

// File: rtl/i2c_controller_xfer.sv
// Single-byte I2C initiator: START, 7-bit address + R/W, address ACK,
// one data byte written or read, data ACK/NACK, STOP.
// - clk, rst : system clock, asynchronous active-low reset
// - bus      : i2c_controller_xfer_if.master (request, line enables, status)
// All line enables and status outputs are registered. SCL period is
// 4*CLK_DIV clk cycles; SCL is never read back (no stretching).
module i2c_controller_xfer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input logic                   clk,
    input logic                   rst,
    i2c_controller_xfer_if.master bus
);

    logic     tick;
    quarter_e quarter_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_rw_q, addr_rw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       addr_ack_q, addr_ack_d;
    logic       ack_error_q, ack_error_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       sda_meta_q, sda_sync_q;

    logic       is_read;
    logic       bit_end;
    logic       sample;
    quarter_e   quarter_nxt;
    logic       drive_low;
    logic [1:0] lines;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q != IDLE),
        .tick    (tick),
        .quarter (quarter_q)
    );

    assign is_read = (addr_rw_q[0] == I2C_READ);
    assign bit_end = tick && (quarter_q == Q3);
    assign sample  = tick && (quarter_q == Q2);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_rw_d   = addr_rw_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        addr_ack_d  = addr_ack_q;
        ack_error_d = ack_error_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_rw_d   = {bus.addr, bus.rw};
                    wdata_d     = bus.wdata;
                    ack_error_d = 1'b0;
                    addr_ack_d  = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_end) state_d = ADDR;
            end
            ADDR: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                if (sample) begin
                    if (sda_sync_q == I2C_ACK) addr_ack_d  = 1'b1;
                    else                       ack_error_d = 1'b1;
                end
                if (bit_end) state_d = addr_ack_q ? DATA : STOP;
            end
            DATA: begin
                if (sample && is_read) rx_d = {rx_q[6:0], sda_sync_q};
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = DATA_ACK;
                end
            end
            DATA_ACK: begin
                if (sample && !is_read && (sda_sync_q != I2C_ACK)) ack_error_d = 1'b1;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (is_read && addr_ack_q) rdata_d = rx_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line enables are registered, so they are derived from the state
        // and quarter that will be current after this edge.
        quarter_nxt = tick ? quarter_e'(quarter_q + 2'd1) : quarter_q;
        drive_low   = 1'b0;
        if (state_d == ADDR)
            drive_low = ~addr_rw_q[3'd7 - bit_cnt_d];
        else if (state_d == DATA && addr_rw_q[0] == I2C_WRITE)
            drive_low = ~wdata_q[3'd7 - bit_cnt_d];
        lines    = bus_drive(state_d, quarter_nxt, drive_low);
        scl_oe_d = lines[1];
        sda_oe_d = lines[0];
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            addr_rw_q   <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            addr_ack_q  <= 1'b0;
            ack_error_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_rw_q   <= addr_rw_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            addr_ack_q  <= addr_ack_d;
            ack_error_q <= ack_error_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            sda_meta_q  <= bus.sda_in;
            sda_sync_q  <= sda_meta_q;
        end
    end

    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_controller_xfer.sv
// Directed bench for i2c_controller_xfer with a subordinate model on the
// resolved wired-AND SCL/SDA lines.
module tb_i2c_controller_xfer;

    localparam int unsigned CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_controller_xfer_if bus();

    i2c_controller_xfer #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic slv_sda_oe = 1'b0;
    logic scl_line, sda_line;
    assign scl_line   = ~bus.scl_oe;
    assign sda_line   = ~(bus.sda_oe | slv_sda_oe);
    assign bus.sda_in = sda_line;

    // Subordinate model configuration
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] rd_byte  = 8'h00;

    // Subordinate model state / bus observations
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        rw_seen  = 1'b0;
    int          rises    = 0;
    int          starts   = 0;
    int          stops    = 0;
    logic [31:0] bits     = '0;

    always @(negedge clk) begin
        if (prev_scl && scl_line && prev_sda && !sda_line) begin
            starts     <= starts + 1;
            rises      <= 0;
            bits       <= '0;
            slv_sda_oe <= 1'b0;
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
            stops      <= stops + 1;
            slv_sda_oe <= 1'b0;
        end else if (!prev_scl && scl_line) begin
            rises <= rises + 1;
            bits  <= {bits[30:0], sda_line};
            if (rises == 7) rw_seen <= sda_line;
        end else if (prev_scl && !scl_line) begin
            if (rises == 8)
                slv_sda_oe <= ack_addr;
            else if (rises >= 9 && rises <= 16)
                slv_sda_oe <= (rw_seen && ack_addr) ? ~rd_byte[16 - rises] : 1'b0;
            else if (rises == 17)
                slv_sda_oe <= !rw_seen && ack_data;
            else
                slv_sda_oe <= 1'b0;
        end
        prev_scl <= scl_line;
        prev_sda <= sda_line;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns at #1 after the accept edge.
    task automatic accept(input logic [6:0] a, input logic r, input logic [7:0] w);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.addr  = a;
        bus.rw    = r;
        bus.wdata = w;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts clk edges from the accept edge until done is seen (bounded).
    task automatic wait_done(input int poke_at, output int lat);
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == poke_at) begin
                bus.start = 1'b1;
                bus.addr  = 7'h11;
                bus.rw    = 1'b1;
                bus.wdata = 8'h00;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int s0;
        int p0;

        bus.start = 1'b0;
        bus.addr  = '0;
        bus.rw    = 1'b0;
        bus.wdata = '0;

        // Reset held with start pulsing
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            bus.start = (i % 2 == 0);
            bus.addr  = 7'h4C;
            check("reset_outputs",
                  {19'b0, bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.ack_error, bus.rdata},
                  32'h0);
        end
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);

        // Write 0x4C <- 0xA5, both bytes ACKed
        s0 = starts;
        p0 = stops;
        accept(7'h4C, 1'b0, 8'hA5);
        check("write_busy_after_accept", bus.busy, 1);
        wait_done(-1, lat);
        check("write_latency", lat, 320);
        check("write_busy_at_done", bus.busy, 0);
        check("write_ack_error", bus.ack_error, 0);
        check("write_rises", rises, 19);
        check("write_bits", bits[18:0], {7'h4C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});
        check("write_start_cond", starts - s0, 1);
        check("write_stop_cond", stops - p0, 1);
        @(posedge clk);
        #1;
        check("write_done_pulse_lines", {bus.done, bus.scl_oe, bus.sda_oe}, 0);

        // Read 0x4C -> 0x3C
        rd_byte = 8'h3C;
        accept(7'h4C, 1'b1, 8'h00);
        wait_done(-1, lat);
        check("read_latency", lat, 320);
        check("read_rdata", bus.rdata, 8'h3C);
        check("read_ack_error", bus.ack_error, 0);
        check("read_rises", rises, 19);
        check("read_bits", bits[18:0], {7'h4C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0});

        // Address NACK on a read: short transaction, rdata kept
        ack_addr = 1'b0;
        s0 = starts;
        p0 = stops;
        accept(7'h4C, 1'b1, 8'h00);
        wait_done(-1, lat);
        check("nack_latency", lat, 176);
        check("nack_ack_error", bus.ack_error, 1);
        check("nack_rdata_kept", bus.rdata, 8'h3C);
        check("nack_rises", rises, 10);
        check("nack_bits", bits[9:0], {7'h4C, 1'b1, 1'b1, 1'b0});
        check("nack_stop_cond", stops - p0, 1);
        ack_addr = 1'b1;

        // Write data NACK
        ack_data = 1'b0;
        accept(7'h4C, 1'b0, 8'hA5);
        wait_done(-1, lat);
        check("dnack_latency", lat, 320);
        check("dnack_ack_error", bus.ack_error, 1);
        check("dnack_bits", bits[18:0], {7'h4C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0});
        ack_data = 1'b1;

        // start re-pulsed while busy is ignored
        s0 = starts;
        accept(7'h4C, 1'b0, 8'hA5);
        wait_done(50, lat);
        check("busy_ign_latency", lat, 320);
        check("busy_ign_ack_error", bus.ack_error, 0);
        check("busy_ign_bits", bits[18:0], {7'h4C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});
        repeat (300) @(posedge clk);
        #1;
        check("busy_ign_idle_after", bus.busy, 0);
        check("busy_ign_single_start", starts - s0, 1);

        // Reset during data bit 3 (Q1: SCL low, SDA low for 0xA5)
        accept(7'h4C, 1'b0, 8'hA5);
        repeat (212) @(posedge clk);
        #1;
        check("mid_lines_before_reset", {bus.busy, bus.scl_oe, bus.sda_oe}, 3'b111);
        rst = 1'b0;
        #1;
        check("mid_reset_release", {bus.busy, bus.scl_oe, bus.sda_oe, bus.done}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_reset_stays_idle", {bus.busy, bus.scl_oe, bus.sda_oe}, 0);

        // Normal write after the aborted one
        accept(7'h4C, 1'b0, 8'h5A);
        wait_done(-1, lat);
        check("post_reset_latency", lat, 320);
        check("post_reset_ack_error", bus.ack_error, 0);
        check("post_reset_bits", bits[18:0], {7'h4C, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
